// File: rtl/sample_pacer_if.sv
// Purpose: bundles the decoder-side write port and the modulator-side sample port of sample_pacer.
// Ports: master drives sample_in/new_sample/clr_flags and observes the rest; slave is the pacer side.
// Signals: sample_out/sample_valid/running/level/overflow/underflow are driven by the pacer.
interface sample_pacer_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 6
);
    logic [DATA_W-1:0]   sample_in;
    logic                new_sample;
    logic                clr_flags;
    logic [DATA_W-1:0]   sample_out;
    logic                sample_valid;
    logic                running;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic                underflow;

    modport master (
        output sample_in, new_sample, clr_flags,
        input  sample_out, sample_valid, running, level, overflow, underflow
    );

    modport slave (
        input  sample_in, new_sample, clr_flags,
        output sample_out, sample_valid, running, level, overflow, underflow
    );
endinterface

// File: rtl/sample_pacer.sv
// Purpose: absorbs bursty decoder samples in a FIFO and re-issues them at one sample per DIV clocks.
// Latency: first sample_valid DIV+1 cycles after level reaches PREFILL; then exactly every DIV cycles.
// Backpressure: none upstream; writes to a full FIFO (without a same-cycle pop) are dropped and flagged.
//
// Ports: clk, rst (async, active-high), bus (sample_pacer_if.slave) carrying
//   sample_in/new_sample/clr_flags in and sample_out/sample_valid/running/level/overflow/underflow out.
// Optional feature: define SAMPLE_PACER_HOLD_EN to keep the last emitted sample on sample_out
//   during an underflow instead of driving IDLE_VAL.
module sample_pacer #(
    parameter int                 DATA_W     = 8,
    parameter int                 DEPTH_LOG2 = 6,
    parameter int                 DIV        = 10,
    parameter int                 PREFILL    = 32,
    parameter logic [DATA_W-1:0]  IDLE_VAL   = 8'h80
) (
    input  logic         clk,
    input  logic         rst,
    sample_pacer_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] PREFILL_L = LVL_W'(PREFILL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;

    // Pacing FSM and registered outputs
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     sample_out_q;
    logic                  sample_valid_q;
    logic                  running_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  tick;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [DATA_W-1:0]     head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == DEPTH_L);

    // A tick only exists in ST_RUN; the counter is parked at 0 in ST_FILL.
    assign tick = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

    // Pop decisions use the pre-write level, so a write landing on an
    // empty FIFO in the tick cycle still counts as an underflow.
    assign pop  = tick && !fifo_empty;

    // A pop in the same cycle frees the slot a full-FIFO write needs.
    assign push = bus.new_sample && (!fifo_full || pop);
    assign drop = bus.new_sample && fifo_full && !pop;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.sample_in;
        end
    end

    // Pointers wrap naturally at DEPTH; level is tracked separately so
    // full and empty are unambiguous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FILL;
            cnt_q          <= '0;
            sample_out_q   <= IDLE_VAL;
            sample_valid_q <= 1'b0;
            running_q      <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            // Every tick produces a pulse, including the underflow tick.
            sample_valid_q <= tick;

`ifdef SAMPLE_PACER_HOLD_EN
            // Underflow leaves the previously emitted sample on the output.
            if (pop) begin
                sample_out_q <= head;
            end
`else
            if (pop) begin
                sample_out_q <= head;
            end else if (tick) begin
                sample_out_q <= IDLE_VAL;
            end
`endif

            // Sticky flags: a set event in the clearing cycle takes priority.
            overflow_q  <= drop | (overflow_q & ~bus.clr_flags);
            underflow_q <= (tick & fifo_empty) | (underflow_q & ~bus.clr_flags);

            case (state_q)
                ST_FILL: begin
                    cnt_q <= '0;
                    if (level_q >= PREFILL_L) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        cnt_q <= '0;
                        // Starved: go back and rebuild the prefill cushion.
                        if (fifo_empty) begin
                            state_q   <= ST_FILL;
                            running_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_FILL;
                    cnt_q     <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.running      = running_q;
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
